// File: rtl/lsu_pkg.sv
//==============================================================================
// Module : lsu_pkg
// Brief  : Shared state encoding, funct3 codes and request legality check.
// Rev    : 1.0
//==============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  localparam logic [2:0] c_F3_B  = 3'b000;
  localparam logic [2:0] c_F3_H  = 3'b001;
  localparam logic [2:0] c_F3_W  = 3'b010;
  localparam logic [2:0] c_F3_BU = 3'b100;
  localparam logic [2:0] c_F3_HU = 3'b101;

  // Unsigned variants exist only for loads; halfwords and words must be naturally aligned.
  function automatic logic req_legal(input logic [2:0] funct3,
                                     input logic       we,
                                     input logic [1:0] addr_lo);
    logic ok;
    ok = 1'b0;
    case (funct3)
      c_F3_B:  ok = 1'b1;
      c_F3_H:  ok = ~addr_lo[0];
      c_F3_W:  ok = (addr_lo == 2'b00);
      c_F3_BU: ok = ~we;
      c_F3_HU: ok = ~we & ~addr_lo[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_extend.sv
//==============================================================================
// Module : load_extend
// Brief  : Selects the addressed lane of a read word and sign/zero extends it.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = 8'h00;
    case (i_addr_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      c_F3_B:  o_data = {{24{w_byte[7]}}, w_byte};
      c_F3_H:  o_data = {{16{w_half[15]}}, w_half};
      c_F3_BU: o_data = {24'h000000, w_byte};
      c_F3_HU: o_data = {16'h0000, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
//==============================================================================
// Module : load_store_unit
// Brief  : Single-outstanding RISC-V load/store unit with lane shaping.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  err,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  lsu_state_t            r_state;
  lsu_state_t            w_next;
  logic                  w_legal;
  logic                  w_accept;
  logic                  r_we;
  logic                  r_err;
  logic [2:0]            r_funct3;
  logic [1:0]            r_addr_lo;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [3:0]            r_mem_be;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_load;

  assign w_legal = req_legal(req_funct3, req_we, req_addr[1:0]);

  // Store data is replicated across lanes so memory can pick it up under any enable.
  always_comb begin
    w_be    = 4'b0000;
    w_wdata = '0;
    case (req_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
      end
    endcase
    if (!req_we) begin
      w_wdata = '0;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    req_ready  = 1'b0;
    stall      = 1'b0;
    mem_req    = 1'b0;
    resp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && w_legal) begin
          w_accept = 1'b1;
          stall    = 1'b1;
          w_next   = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        mem_req = 1'b1;
        stall   = 1'b1;
        if (mem_ack) begin
          w_next = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .i_funct3  (r_funct3),
    .i_addr_lo (r_addr_lo),
    .i_rdata   (mem_rdata),
    .o_data    (w_load)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr_lo   <= 2'b00;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= 4'b0000;
      r_rdata     <= '0;
    end else begin
      r_state <= w_next;
      r_err   <= (r_state == ST_IDLE) && req_valid && !w_legal;
      if (w_accept) begin
        r_we        <= req_we;
        r_funct3    <= req_funct3;
        r_addr_lo   <= req_addr[1:0];
        r_mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
        r_mem_wdata <= w_wdata;
        r_mem_be    <= w_be;
      end
      if ((r_state == ST_ACCESS) && mem_ack) begin
        r_rdata <= r_we ? '0 : w_load;
      end
    end
  end

  assign mem_we     = r_we & mem_req;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign err        = r_err;
  assign resp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
//==============================================================================
// Module : tb_load_store_unit
// Brief  : Directed and randomized checks of load_store_unit against a model.
// Rev    : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, req_valid, req_we, mem_ack;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata, mem_rdata;
  logic        req_ready, resp_valid, err, stall, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  int          n_checks = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .err(err), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: byte-lane arithmetic straight from the access rules.
  function automatic bit m_legal(input bit [2:0] f3, input bit we, input bit [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !we;
      3'd5:    return !we && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit [31:0] m_be(input bit [2:0] f3, input bit [31:0] a);
    if (f3 % 4 == 0) return 32'(1 << (a % 4));
    if (f3 % 4 == 1) return 32'(3 << (a % 4));
    return 32'd15;
  endfunction

  function automatic bit [31:0] m_wdata(input bit [2:0] f3, input bit we, input bit [31:0] wd);
    if (!we) return 32'd0;
    if (f3 % 4 == 0) return (wd & 32'hFF) * 32'h01010101;
    if (f3 % 4 == 1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  function automatic bit [31:0] m_load(input bit [2:0] f3, input bit [31:0] a, input bit [31:0] rd);
    longint v;
    int     bits;
    if (f3 % 4 == 2) return rd;
    bits = (f3 % 4 == 0) ? 8 : 16;
    v = longint'((rd >> (8 * (a % 4))) & ((32'd1 << bits) - 32'd1));
    if (f3 < 4 && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return 32'(v);
  endfunction

  task automatic run_access(input string tag, input bit we, input bit [2:0] f3,
                            input bit [31:0] a, input bit [31:0] wd, input bit [31:0] rd,
                            input bit [31:0] exp_rdata, input int dly);
    int n_stall;
    n_stall = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    #1;
    check({tag, ".ready_idle"}, 32'(req_ready), 32'd1);
    n_stall += int'(stall);
    for (int k = 1; k <= dly; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
      mem_ack = (k == dly);
      mem_rdata = (k == dly) ? rd : $urandom;
      #1;
      n_stall += int'(stall);
      check({tag, ".mem_req"}, 32'(mem_req), 32'd1);
      check({tag, ".mem_we"}, 32'(mem_we), 32'(we));
      check({tag, ".mem_addr"}, mem_addr, a & ~32'd3);
      check({tag, ".mem_be"}, 32'(mem_be), m_be(f3, a));
      check({tag, ".mem_wdata"}, mem_wdata, m_wdata(f3, we, wd));
      check({tag, ".ready_access"}, 32'(req_ready), 32'd0);
      check({tag, ".resp_early"}, 32'(resp_valid), 32'd0);
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".resp_rdata"}, resp_rdata, exp_rdata);
    check({tag, ".stall_resp"}, 32'(stall), 32'd0);
    check({tag, ".ready_resp"}, 32'(req_ready), 32'd0);
    check({tag, ".mem_req_resp"}, 32'(mem_req), 32'd0);
    check({tag, ".stall_cycles"}, 32'(n_stall), 32'(dly + 1));
    @(posedge clk); #2;
    check({tag, ".resp_pulse"}, 32'(resp_valid), 32'd0);
    check({tag, ".rdata_hold"}, resp_rdata, exp_rdata);
    check({tag, ".ready_back"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_illegal(input string tag, input bit we, input bit [2:0] f3, input bit [31:0] a);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = $urandom;
    #1;
    check({tag, ".stall"}, 32'(stall), 32'd0);
    check({tag, ".err_early"}, 32'(err), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    check({tag, ".err"}, 32'(err), 32'd1);
    check({tag, ".mem_req"}, 32'(mem_req), 32'd0);
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, ".stall_after"}, 32'(stall), 32'd0);
    @(posedge clk); #2;
    check({tag, ".err_pulse"}, 32'(err), 32'd0);
    check({tag, ".mem_req_after"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    bit        r_we_t;
    bit [2:0]  r_f3;
    bit [31:0] r_a, r_wd, r_rd;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; mem_ack = 1'b0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.stall", 32'(stall), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    check("rst.mem_addr", mem_addr, 32'd0);
    check("rst.mem_wdata", mem_wdata, 32'd0);
    check("rst.resp_rdata", resp_rdata, 32'd0);
    check("rst.req_ready", 32'(req_ready), 32'd1);
    rst = 1'b0;

    run_access("sw_100", 1'b1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 32'h0, 3);
    run_access("lb_103", 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 32'hFFFFFF80, 2);
    run_access("lbu_103", 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 32'h00000080, 1);
    run_access("sh_102", 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 32'h0, 32'h0, 2);
    run_illegal("lw_101", 1'b0, 3'b010, 32'h101);
    run_illegal("sh_101", 1'b1, 3'b001, 32'h101);
    run_illegal("f3_011", 1'b0, 3'b011, 32'h0);
    run_illegal("sbu", 1'b1, 3'b100, 32'h4);
    run_access("lh_002", 1'b0, 3'b001, 32'h002, 32'h0, 32'h7FFF0000, 32'h00007FFF, 1);

    // Reset in the second ACCESS cycle, then a late ack that must be ignored.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h200; req_wdata = 32'h12345678;
    @(posedge clk); #1;
    req_valid = 1'b0;
    #1;
    check("abort.access1", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort.access2", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    check("abort.mem_req", 32'(mem_req), 32'd0);
    check("abort.resp", 32'(resp_valid), 32'd0);
    check("abort.mem_addr", mem_addr, 32'd0);
    check("abort.ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    check("abort.resp_late", 32'(resp_valid), 32'd0);
    check("abort.mem_req_late", 32'(mem_req), 32'd0);
    check("abort.rdata", resp_rdata, 32'd0);

    for (int i = 0; i < 40; i++) begin
      // Stray ack while idle must not produce a response.
      @(posedge clk); #1;
      mem_ack = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      #1;
      check("rand.stray_ack", 32'(resp_valid), 32'd0);

      r_we_t = 1'($urandom);
      r_f3   = 3'($urandom);
      r_a    = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: r_f3 = 3'd0;
          1: r_f3 = 3'd1;
          2: r_f3 = 3'd2;
          3: begin r_f3 = 3'd4; r_we_t = 1'b0; end
          default: begin r_f3 = 3'd5; r_we_t = 1'b0; end
        endcase
        if (r_f3 % 4 == 1) r_a[0] = 1'b0;
        if (r_f3 % 4 == 2) r_a[1:0] = 2'b00;
      end
      if (m_legal(r_f3, r_we_t, r_a))
        run_access("rand", r_we_t, r_f3, r_a, r_wd, r_rd,
                   r_we_t ? 32'd0 : m_load(r_f3, r_a, r_rd), $urandom_range(1, 4));
      else
        run_illegal("rand_bad", r_we_t, r_f3, r_a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
